// File: rtl/gf_link_pkg.sv
// gf_link_pkg: shared state encoding, width clamp and sizing for the GF multiplier host link.
package gf_link_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 2;
  localparam int unsigned RESULT_WIDTH = 2 * DATA_WIDTH_DEFAULT;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    RUN,
    CAPTURE,
    DONE
  } state_e;

  // A zero or oversized field width falls back to the full operand width.
  function automatic int unsigned clamp_width(input int unsigned w, input int unsigned dw);
    return (w == 0 || w > dw) ? dw : w;
  endfunction

endpackage

// File: rtl/gf_link_shifter.sv
// gf_link_shifter: MSB-first shift register; parallel load with serial out, or serial in with parallel out.
module gf_link_shifter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic         ser_o,
  output logic [W-1:0] par_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb sr_d = load_i ? data_i : shift_i ? ((sr_q << 1) | W'(ser_i)) : sr_q;

  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) sr_q <= '0;
    else sr_q <= sr_d;

  assign ser_o = sr_q[W-1];
  assign par_o = sr_q;

endmodule

// File: rtl/gf_mult_host.sv
// gf_mult_host: host link controller that serializes operands to the sequential GF multiplier,
// runs the enable/finish handshake with a timeout, and deserializes the product.
module gf_mult_host
  import gf_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         op_a,
  input  logic [DATA_WIDTH-1:0]         op_b,
  input  logic [$clog2(DATA_WIDTH):0]   width,
  output logic                          busy,
  output logic                          result_valid,
  output logic [2*DATA_WIDTH-1:0]       result,
  output logic                          timeout_err,
  output logic                          link_a,
  output logic                          link_b,
  output logic                          link_enable,
  output logic [$clog2(DATA_WIDTH):0]   link_width,
  input  logic                          link_out,
  input  logic                          link_finish
);

  localparam int RW = 2 * DATA_WIDTH;
  localparam int WW = $clog2(DATA_WIDTH) + 1;
  localparam int CW = $clog2(RW);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic [WW-1:0]   width_q, width_d;
  logic [WW-1:0]   link_width_q, link_width_d;
  logic [RW-1:0]   result_q, result_d;
  logic            timeout_q, timeout_d;
  logic            accept;
  logic            ser_a, ser_b;
  logic [RW-1:0]   prod;
  logic [DATA_WIDTH-1:0] unused_par_a, unused_par_b;
  logic            unused_ser_r;

  gf_link_shifter #(.W(DATA_WIDTH)) u_sh_a (
    .clk(clk), .rst_ni(resetn), .load_i(accept), .data_i(op_a),
    .shift_i(state_q == SHIFT), .ser_i(1'b0), .ser_o(ser_a), .par_o(unused_par_a)
  );

  gf_link_shifter #(.W(DATA_WIDTH)) u_sh_b (
    .clk(clk), .rst_ni(resetn), .load_i(accept), .data_i(op_b),
    .shift_i(state_q == SHIFT), .ser_i(1'b0), .ser_o(ser_b), .par_o(unused_par_b)
  );

  gf_link_shifter #(.W(RW)) u_sh_r (
    .clk(clk), .rst_ni(resetn), .load_i(1'b0), .data_i('0),
    .shift_i(state_q == CAPTURE), .ser_i(link_out), .ser_o(unused_ser_r), .par_o(prod)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    width_d      = width_q;
    link_width_d = link_width_q;
    result_d     = result_q;
    timeout_d    = timeout_q;
    accept       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        accept    = 1'b1;
        width_d   = WW'(clamp_width(32'(width), DATA_WIDTH));
        timeout_d = 1'b0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d        = '0;
          wait_d       = '0;
          link_width_d = width_q;
          state_d      = RUN;
        end
      end
      RUN: begin
        wait_d = wait_q + 1'b1;
        // finish has priority over a timeout expiring in the same cycle
        if (link_finish) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      CAPTURE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RW - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = prod;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      width_q      <= '0;
      link_width_q <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      width_q      <= width_d;
      link_width_q <= link_width_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
    end

  // The finished product is already complete in DONE, so present it alongside the valid pulse.
  assign result       = (state_q == DONE) ? prod : result_q;
  assign result_valid = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign timeout_err  = timeout_q;
  assign link_enable  = state_q == RUN;
  assign link_width   = link_width_q;
  assign link_a       = (state_q == SHIFT) & ser_a;
  assign link_b       = (state_q == SHIFT) & ser_b;

endmodule

// File: tb/tb_gf_mult_host.sv
// tb_gf_mult_host: drives gf_mult_host against a behavioural carry-less multiplier top model.
module tb_gf_mult_host;

  localparam int DW = 4;
  localparam int RW = 2 * DW;
  localparam int WW = $clog2(DW) + 1;
  localparam int TO = 16;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic [WW-1:0] width = '0;
  logic busy, result_valid, timeout_err, link_a, link_b, link_enable, link_out, link_finish;
  logic [RW-1:0] result;
  logic [WW-1:0] link_width;

  int n_chk = 0, n_fail = 0, n_valid = 0;
  logic [RW-1:0] exp_q[$];

  logic hang = 1'b0, fin_force = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [RW-1:0] m_p = '0;
  int m_cnt = 0, m_idx = -1;
  logic m_fin;

  always #5 clk = ~clk;

  gf_mult_host #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_a(op_a), .op_b(op_b), .width(width),
    .busy(busy), .result_valid(result_valid), .result(result), .timeout_err(timeout_err),
    .link_a(link_a), .link_b(link_b), .link_enable(link_enable), .link_width(link_width),
    .link_out(link_out), .link_finish(link_finish)
  );

  function automatic logic [RW-1:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [RW-1:0] p;
    p = '0;
    for (int i = 0; i < DW; i++) if (b[i]) p ^= RW'(a) << i;
    return p;
  endfunction

  // Multiplier top model: gathers bits while idle, finishes 3 cycles after enable, streams product MSB first.
  assign m_fin       = link_enable && !hang && m_cnt == 3;
  assign link_finish = m_fin | fin_force;
  assign link_out    = (m_idx >= 0) ? m_p[m_idx] : 1'b0;

  always @(posedge clk) begin
    m_cnt <= link_enable ? m_cnt + 1 : 0;
    if (!link_enable) begin
      m_a <= {m_a[DW-2:0], link_a};
      m_b <= {m_b[DW-2:0], link_b};
    end
    if (m_fin) begin
      m_p   <= clmul(m_a, m_b);
      m_idx <= RW - 1;
    end else if (m_idx >= 0) m_idx <= m_idx - 1;
  end

  always @(negedge clk) if (result_valid) begin
    logic [RW-1:0] e;
    n_valid++;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_result_valid: got result %h with nothing expected", result);
    end else begin
      e = exp_q.pop_front();
      if (result !== e) begin
        n_fail++;
        $display("FAIL scoreboard_result: got %h expected %h", result, e);
      end
    end
  end

  // Caller must be at a falling edge; ends at the falling edge after result_valid.
  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [WW-1:0] w, input bit noise);
    int cyc, run, v0;
    logic [WW-1:0] ew;
    logic [RW-1:0] e;
    ew = (w == 0 || w > DW) ? WW'(DW) : w;
    e = clmul(a, b);
    v0 = n_valid;
    start = 1'b1; op_a = a; op_b = b; width = w;
    exp_q.push_back(e);
    cyc = 0; run = 0;
    while (!result_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      fin_force = 1'b0;
      if (cyc == 1) begin
        n_chk++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
          n_fail++;
          $display("FAIL accept: got busy=%b timeout_err=%b expected busy=1 timeout_err=0", busy, timeout_err);
        end
      end
      if (cyc <= DW) begin
        n_chk++;
        if ({link_a, link_b} !== {a[DW-cyc], b[DW-cyc]}) begin
          n_fail++;
          $display("FAIL shift_bit%0d: got a=%b b=%b expected a=%b b=%b", cyc - 1, link_a, link_b, a[DW-cyc], b[DW-cyc]);
        end
      end
      if (link_enable) begin
        run++;
        n_chk++;
        if (link_width !== ew || {link_a, link_b} !== 2'b00) begin
          n_fail++;
          $display("FAIL run_link: got width=%0d a=%b b=%b expected width=%0d a=0 b=0", link_width, link_a, link_b, ew);
        end
      end
      if (noise) begin
        start = (cyc == 2 || cyc == 12);
        fin_force = (cyc == 2);
        op_a = ~a; op_b = ~b;
      end
    end
    n_chk++;
    if (run != 4) begin
      n_fail++;
      $display("FAIL run_cycles: got %0d expected 4", run);
    end
    n_chk++;
    if (cyc + 1 != 1 + DW + 4 + RW + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d expected %0d", cyc + 1, 1 + DW + 4 + RW + 1);
    end
    @(negedge clk);
    n_chk++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== e || n_valid != v0 + 1) begin
      n_fail++;
      $display("FAIL after_done: got valid=%b busy=%b result=%h pulses=%0d expected 0 0 %h 1",
               result_valid, busy, result, n_valid - v0, e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, result_valid, result, timeout_err, link_enable, link_width, link_a, link_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b result=%h terr=%b en=%b w=%0d a=%b b=%b expected all 0",
               busy, result_valid, result, timeout_err, link_enable, link_width, link_a, link_b);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_op(4'b1011, 4'b0110, 3'd4, 1'b0);
    n_chk++;
    if (result !== 8'h3A) begin
      n_fail++;
      $display("FAIL basic_result: got %h expected 3a", result);
    end
  endtask

  task automatic test_width_clamp();
    do_op(4'h7, 4'h9, 3'd0, 1'b0);
    do_op(4'hC, 4'h5, 3'd7, 1'b0);
    do_op(4'h3, 4'hE, 3'd2, 1'b0);
  endtask

  task automatic test_timeout();
    int cyc;
    hang = 1'b1;
    start = 1'b1; op_a = 4'h3; op_b = 4'h5; width = 3'd4;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (busy && cyc < 100);
    n_chk++;
    if (cyc != 1 + DW + TO) begin
      n_fail++;
      $display("FAIL timeout_cycles: got busy low at %0d expected %0d", cyc, 1 + DW + TO);
    end
    n_chk++;
    if (timeout_err !== 1'b1 || link_enable !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: got terr=%b en=%b busy=%b valid=%b expected 1 0 0 0",
               timeout_err, link_enable, busy, result_valid);
    end
    hang = 1'b0;
    @(negedge clk);
    n_chk++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
    end
    do_op(4'h6, 4'hB, 3'd4, 1'b0);
  endtask

  task automatic test_noise();
    do_op(4'hD, 4'h3, 3'd4, 1'b1);
  endtask

  task automatic test_reset_mid();
    int cyc;
    start = 1'b1; op_a = 4'h9; op_b = 4'h7; width = 3'd4;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (!link_enable && cyc < 50);
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (link_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_enable: got %b expected 0", link_enable);
    end
    n_chk++;
    if ({busy, result_valid, result, timeout_err, link_width, link_a, link_b} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got busy=%b valid=%b result=%h terr=%b w=%0d a=%b b=%b expected all 0",
               busy, result_valid, result, timeout_err, link_width, link_a, link_b);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_op(4'hF, 4'hF, 3'd4, 1'b0);
    n_chk++;
    if (result !== 8'h55) begin
      n_fail++;
      $display("FAIL post_reset_result: got %h expected 55", result);
    end
  endtask

  task automatic test_back_to_back();
    do_op(4'hA, 4'h3, 3'd4, 1'b0);
    do_op(4'h5, 4'hC, 3'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width_clamp();
    test_timeout();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
